// File: rtl/odd_even_merge_unloader.sv
// Captures one sorted vector in a single cycle and drains it one element per
// valid/ready handshake, element 0 first. A y_valid that cannot be taken is dropped and flagged.
module odd_even_merge_unloader #(
  parameter int unsigned LOG_INPUT  = 7,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  y_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0]  y,
  output logic [DATA_WIDTH-1:0]                 m_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [LOG_INPUT-1:0]                  m_index,
  output logic                                  m_last,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int unsigned N = 2 ** LOG_INPUT;
  localparam logic [LOG_INPUT-1:0] LastIdx = LOG_INPUT'(N - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                 state_q, state_d;
  logic [LOG_INPUT-1:0]   index_q, index_d;
  logic                   overrun_q, overrun_d;
  logic                   load;
  logic                   handshake;
  logic                   at_last;
  logic [DATA_WIDTH-1:0]  buffer_q [N];

  assign m_valid   = (state_q == StStream);
  assign handshake = m_valid & m_ready;
  assign at_last   = (index_q == LastIdx);

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (y_valid) begin
          load    = 1'b1;
          index_d = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (handshake) begin
          if (at_last) begin
            // Final handshake either reloads seamlessly or leaves; index never wraps.
            index_d = '0;
            if (y_valid) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            index_d = index_q + 1'b1;
          end
        end
        if (y_valid && !(handshake && at_last)) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      index_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      overrun_q <= overrun_d;
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) begin
        buffer_q[i] <= y[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign m_data  = m_valid ? buffer_q[index_q] : '0;
  assign m_index = m_valid ? index_q : '0;
  assign m_last  = m_valid & at_last;
  assign busy    = m_valid;
  assign overrun = overrun_q;

endmodule

// File: doc/odd_even_merge_unloader.md
Name: odd_even_merge_unloader

Overview:
- Consumer end of the sorting network's output interface. Captures one sorted vector (y, y_valid) in a single cycle.
- Streams its 2**LOG_INPUT elements out one per handshake on a valid/ready stream, element 0 first.
- Sits between the merge-network top and narrow downstream logic (FIFO, DMA writer).
- Raises busy while draining, so upstream control can hold off the next x_valid.

Parameters:
LOG_INPUT, 7, log2 of elements per vector; N = 2**LOG_INPUT
DATA_WIDTH, 32, bits per element

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
y_valid  input  1  one-cycle strobe: y holds a complete sorted vector
y  input  DATA_WIDTH*N  sorted vector; element i = y[i*DATA_WIDTH +: DATA_WIDTH]
m_data  output  DATA_WIDTH  current element
m_valid  output  1  m_data/m_index/m_last valid
m_ready  input  1  downstream accepts when m_valid & m_ready
m_index  output  LOG_INPUT  element index of m_data
m_last  output  1  high with element N-1
busy  output  1  vector held and not yet fully drained
overrun  output  1  sticky: a y_valid was dropped

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, index=0. m_valid, m_last, busy, overrun = 0. m_data, m_index = 0. Vector buffer contents are don't-care.
- States: IDLE, STREAM.
- IDLE:
  - y_valid=1: capture y into buffer, index<=0, go to STREAM.
  - m_valid and busy go 1 the next cycle.
  - Latency: y_valid at edge t → m_valid=1 with element 0 after edge t.
- STREAM:
  - m_valid=1; m_data = buffer element[index]; m_index = index; m_last = (index==N-1); busy=1.
  - Handshake (m_valid & m_ready): index increments.
  - Handshake with m_last=1:
    - y_valid=0: go to IDLE; m_valid and busy drop next cycle.
    - y_valid=1 same cycle: capture new vector, index<=0, stay in STREAM. No bubble; element 0 of the new vector is presented the next cycle.
- Stall: while m_valid & ~m_ready, m_data, m_index and m_last hold stable. m_valid never deasserts without a handshake.
- Overrun: y_valid=1 in STREAM other than on the final handshake cycle → input dropped, buffer untouched, overrun<=1. overrun clears only on reset.
- Throughput: N cycles per vector with m_ready tied high; back-to-back vectors stream continuously.
- m_data is driven from registered buffer and index only; no combinational path from y to m_data.
- index is LOG_INPUT bits and never wraps past N-1, because the final handshake always reloads or leaves STREAM.
- Reset asserted mid-stream aborts the vector immediately; after release the block is in IDLE and accepts the next y_valid.
- Data is opaque; no signed/ascending interpretation.

Test Plan:
Use LOG_INPUT=2, DATA_WIDTH=8 unless noted.
- Basic: y=0x40302010, y_valid pulse, m_ready=1 → m_valid from next cycle for 4 cycles; m_data 10,20,30,40; m_index 0..3; m_last only on 40; busy falls with m_valid.
- Backpressure: same vector, m_ready pattern 1,0,0,1,1,0,1 → 4 handshakes total; m_data/m_index held during stalls; no element lost or repeated.
- Back-to-back: vector A=0x04030201, then y_valid with B=0x08070605 on A's m_last handshake cycle → 01,02,03,04,05,06,07,08 on 8 consecutive cycles; m_last on 04 and 08; overrun=0.
- Overrun: y_valid with 0xDDCCBBAA while element 1 of 0x04030201 is presented → stream still 01..04; overrun=1 and stays 1 through later vectors until rst=0.
- Reset mid-stream: drop rst after 2 handshakes → m_valid, busy, m_last, overrun = 0 immediately (asynchronous). After release, new y=0x11223344 streams 44,33,22,11.
- Default-size smoke: LOG_INPUT=7, DATA_WIDTH=32, element i = i*3 → 128 handshakes with m_ready=1; m_last only at m_index=127; all values match.
